// File: rtl/data_memory_pipelined_if.sv
// Request/response bus between the MEM stage and the data memory.
// master = requester (core MEM stage), slave = data memory.
interface data_memory_pipelined_if;
    logic        MEM_req_valid;
    logic        MEM_req_ready;
    logic        MEM_req_write;
    logic [1:0]  MEM_req_length;
    logic        MEM_req_signed;
    logic [31:0] MEM_req_address;
    logic [31:0] MEM_req_wdata;
    logic        MEM_resp_valid;
    logic        MEM_resp_ready;
    logic [31:0] MEM_resp_rdata;
    logic        MEM_resp_fault;

    modport master (
        output MEM_req_valid, MEM_req_write, MEM_req_length, MEM_req_signed,
               MEM_req_address, MEM_req_wdata, MEM_resp_ready,
        input  MEM_req_ready, MEM_resp_valid, MEM_resp_rdata, MEM_resp_fault
    );

    modport slave (
        input  MEM_req_valid, MEM_req_write, MEM_req_length, MEM_req_signed,
               MEM_req_address, MEM_req_wdata, MEM_resp_ready,
        output MEM_req_ready, MEM_resp_valid, MEM_resp_rdata, MEM_resp_fault
    );
endinterface

// File: rtl/data_memory_pipelined.sv
// Word-organised, big-endian data memory for the MEM stage.
// One request outstanding at a time; configurable read latency; faults on
// misaligned or out-of-range accesses; optional zeroing sweep after reset.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | post-reset sweep, zero one word per cycle, no requests
// ST_IDLE  | ready for a request; stores commit on the acceptance edge
// ST_WAIT  | counting down the read latency
// ST_RESP  | response presented, held until the consumer takes it
module data_memory_pipelined #(
    parameter logic [31:0] BASE_ADDRESS   = 32'h0000_1000,
    parameter int          DEPTH_WORDS    = 256,
    parameter int          READ_LATENCY   = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                   SYS_clk,
    input  logic                   SYS_reset,
    data_memory_pipelined_if.slave mem_bus
);

    localparam int              AW          = $clog2(DEPTH_WORDS);
    localparam logic [32:0]     END_ADDRESS = {1'b0, BASE_ADDRESS} + 33'(4 * DEPTH_WORDS);
    localparam logic [AW-1:0]   BASE_WORD   = BASE_ADDRESS[AW+1:2];
    localparam logic [AW-1:0]   LAST_WORD   = AW'(DEPTH_WORDS - 1);
    localparam logic [3:0]      CNT_LOAD    = 4'(READ_LATENCY - 1);
    localparam logic [1:0]      LEN_NOP     = 2'b00;
    localparam logic [1:0]      LEN_BYTE    = 2'b01;
    localparam logic [1:0]      LEN_HALF    = 2'b10;
    localparam logic [1:0]      LEN_WORD    = 2'b11;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    logic [31:0]   r_mem [DEPTH_WORDS];

    state_t        r_state;
    state_t        w_state_next;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_clr_idx;
    logic          r_req_ready;
    logic          r_resp_valid;
    logic [31:0]   r_rdata;
    logic          r_fault;
    logic [31:0]   r_pend_rdata;
    logic          r_pend_fault;

    logic          w_accept;
    logic          w_in_range;
    logic          w_misaligned;
    logic          w_fault;
    logic [AW-1:0] w_word;
    logic [1:0]    w_lane;
    logic [31:0]   w_rd_word;
    logic [7:0]    w_sel_byte;
    logic [15:0]   w_sel_half;
    logic [31:0]   w_load_data;
    logic [31:0]   w_wmask;
    logic [31:0]   w_wbytes;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_idx;
    logic [31:0]   w_mem_wval;

    assign mem_bus.MEM_req_ready  = r_req_ready;
    assign mem_bus.MEM_resp_valid = r_resp_valid;
    assign mem_bus.MEM_resp_rdata = r_rdata;
    assign mem_bus.MEM_resp_fault = r_fault;

    assign w_accept = (r_state == ST_IDLE) && r_req_ready && mem_bus.MEM_req_valid;

    // Address decode: range check in 33 bits so addresses past the top of
    // the array can never wrap back onto a valid word.
    always_comb begin
        w_in_range   = ({1'b0, mem_bus.MEM_req_address} >= {1'b0, BASE_ADDRESS}) &&
                       ({1'b0, mem_bus.MEM_req_address} <  END_ADDRESS);
        w_word       = mem_bus.MEM_req_address[AW+1:2] - BASE_WORD;
        w_lane       = mem_bus.MEM_req_address[1:0];
        w_misaligned = ((mem_bus.MEM_req_length == LEN_HALF) && w_lane[0]) ||
                       ((mem_bus.MEM_req_length == LEN_WORD) && (w_lane != 2'b00));
        w_fault      = (mem_bus.MEM_req_length != LEN_NOP) && (!w_in_range || w_misaligned);
        w_rd_word    = r_mem[w_word];
    end

    // Load path: pick the big-endian lane(s) and extend.
    always_comb begin
        w_sel_byte  = 8'h00;
        w_sel_half  = w_lane[1] ? w_rd_word[15:0] : w_rd_word[31:16];
        w_load_data = 32'h0;
        unique case (w_lane)
            2'd0:    w_sel_byte = w_rd_word[31:24];
            2'd1:    w_sel_byte = w_rd_word[23:16];
            2'd2:    w_sel_byte = w_rd_word[15:8];
            default: w_sel_byte = w_rd_word[7:0];
        endcase
        unique case (mem_bus.MEM_req_length)
            LEN_BYTE: w_load_data = {{24{mem_bus.MEM_req_signed & w_sel_byte[7]}}, w_sel_byte};
            LEN_HALF: w_load_data = {{16{mem_bus.MEM_req_signed & w_sel_half[15]}}, w_sel_half};
            LEN_WORD: w_load_data = w_rd_word;
            default:  w_load_data = 32'h0;
        endcase
        if (mem_bus.MEM_req_write || w_fault) begin
            w_load_data = 32'h0;
        end
    end

    // Store path: right-aligned store data replicated, then masked into place.
    always_comb begin
        w_wmask  = 32'h0;
        w_wbytes = 32'h0;
        unique case (mem_bus.MEM_req_length)
            LEN_BYTE: begin
                w_wmask  = 32'hFF00_0000 >> {w_lane, 3'b000};
                w_wbytes = {4{mem_bus.MEM_req_wdata[7:0]}};
            end
            LEN_HALF: begin
                w_wmask  = w_lane[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
                w_wbytes = {2{mem_bus.MEM_req_wdata[15:0]}};
            end
            LEN_WORD: begin
                w_wmask  = 32'hFFFF_FFFF;
                w_wbytes = mem_bus.MEM_req_wdata;
            end
            default: begin
                w_wmask  = 32'h0;
                w_wbytes = 32'h0;
            end
        endcase
    end

    // Array write port select: clear sweep or an accepted, non-faulting store.
    // A clear write while reset is held only rewrites word 0 with zero,
    // which the sweep does anyway.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_idx  = w_word;
        w_mem_wval = (w_rd_word & ~w_wmask) | (w_wbytes & w_wmask);
        if (r_state == ST_CLEAR) begin
            w_mem_we   = 1'b1;
            w_mem_idx  = r_clr_idx;
            w_mem_wval = 32'h0;
        end else if (w_accept && mem_bus.MEM_req_write && !w_fault &&
                     (mem_bus.MEM_req_length != LEN_NOP)) begin
            w_mem_we = 1'b1;
        end
    end

    // Storage array; not reset so committed stores survive a reset.
    always_ff @(posedge SYS_clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_wval;
        end
    end

    // FSM state register.
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            if (CLEAR_ON_RESET) begin
                r_state <= ST_CLEAR;
            end else begin
                r_state <= ST_IDLE;
            end
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_CLEAR: if (r_clr_idx == LAST_WORD)     w_state_next = ST_IDLE;
            ST_IDLE:  if (w_accept)                   w_state_next = ST_WAIT;
            ST_WAIT:  if (r_cnt == 4'd0)              w_state_next = ST_RESP;
            ST_RESP:  if (mem_bus.MEM_resp_ready)     w_state_next = ST_IDLE;
            default:                                  w_state_next = ST_IDLE;
        endcase
    end

    // Registered handshakes, latency counter, clear index and response data.
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_rdata      <= 32'h0;
            r_fault      <= 1'b0;
            r_pend_rdata <= 32'h0;
            r_pend_fault <= 1'b0;
            r_cnt        <= 4'd0;
            r_clr_idx    <= '0;
        end else begin
            r_req_ready  <= (w_state_next == ST_IDLE);
            r_resp_valid <= (w_state_next == ST_RESP);
            unique case (r_state)
                ST_CLEAR: r_clr_idx <= r_clr_idx + AW'(1);
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cnt        <= CNT_LOAD;
                        r_pend_rdata <= w_load_data;
                        r_pend_fault <= w_fault;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_rdata <= r_pend_rdata;
                        r_fault <= r_pend_fault;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_pipelined.sv
// Bench for data_memory_pipelined: instance A uses defaults (latency 1,
// clear on reset), instance B uses latency 3 with no clear sweep.
// Expected results come from a byte-addressed reference model.
module tb_data_memory_pipelined;

    localparam logic [1:0] LEN_NOP  = 2'b00;
    localparam logic [1:0] LEN_BYTE = 2'b01;
    localparam logic [1:0] LEN_HALF = 2'b10;
    localparam logic [1:0] LEN_WORD = 2'b11;

    logic SYS_clk = 1'b0;
    logic SYS_reset;
    always #5 SYS_clk = ~SYS_clk;

    data_memory_pipelined_if bus_a ();
    data_memory_pipelined_if bus_b ();

    data_memory_pipelined #(
        .BASE_ADDRESS(32'h0000_1000), .DEPTH_WORDS(256),
        .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)
    ) u_dut_a (.SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .mem_bus(bus_a));

    data_memory_pipelined #(
        .BASE_ADDRESS(32'h0000_1000), .DEPTH_WORDS(256),
        .READ_LATENCY(3), .CLEAR_ON_RESET(1'b0)
    ) u_dut_b (.SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .mem_bus(bus_b));

    bit          sel_b;
    logic        req_valid, req_write, req_signed, resp_ready;
    logic [1:0]  req_length;
    logic [31:0] req_address, req_wdata;

    assign bus_a.MEM_req_valid   = req_valid & ~sel_b;
    assign bus_b.MEM_req_valid   = req_valid &  sel_b;
    assign bus_a.MEM_resp_ready  = resp_ready & ~sel_b;
    assign bus_b.MEM_resp_ready  = resp_ready &  sel_b;
    assign bus_a.MEM_req_write   = req_write;
    assign bus_b.MEM_req_write   = req_write;
    assign bus_a.MEM_req_length  = req_length;
    assign bus_b.MEM_req_length  = req_length;
    assign bus_a.MEM_req_signed  = req_signed;
    assign bus_b.MEM_req_signed  = req_signed;
    assign bus_a.MEM_req_address = req_address;
    assign bus_b.MEM_req_address = req_address;
    assign bus_a.MEM_req_wdata   = req_wdata;
    assign bus_b.MEM_req_wdata   = req_wdata;

    logic        w_req_ready, w_resp_valid, w_resp_fault;
    logic [31:0] w_resp_rdata;
    assign w_req_ready  = sel_b ? bus_b.MEM_req_ready  : bus_a.MEM_req_ready;
    assign w_resp_valid = sel_b ? bus_b.MEM_resp_valid : bus_a.MEM_resp_valid;
    assign w_resp_fault = sel_b ? bus_b.MEM_resp_fault : bus_a.MEM_resp_fault;
    assign w_resp_rdata = sel_b ? bus_b.MEM_resp_rdata : bus_a.MEM_resp_rdata;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one flat byte array per instance, byte 0 at 0x1000.
    logic [7:0]  mdl [2][1024];
    logic [31:0] oor_addr [5] = '{32'h0000_0FFC, 32'h0000_1400, 32'h1001_1000,
                                  32'hFFFF_FFFC, 32'h0000_0FFF};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear(input int d);
        for (int i = 0; i < 1024; i++) mdl[d][i] = 8'h00;
    endtask

    function automatic void model_exec(input int d, input bit wr, input logic [1:0] len,
                                       input bit sgn, input logic [31:0] addr,
                                       input logic [31:0] wd,
                                       output logic [31:0] rd, output logic flt);
        int     n;
        longint off;
        longint v;
        n   = (len == LEN_BYTE) ? 1 : (len == LEN_HALF) ? 2 : (len == LEN_WORD) ? 4 : 0;
        rd  = 32'h0;
        flt = 1'b0;
        if (n == 0) return;
        off = longint'(addr) - 64'h1000;
        if (off < 0 || off >= 1024 || (off % n) != 0) begin
            flt = 1'b1;
            return;
        end
        if (wr) begin
            for (int i = 0; i < n; i++) mdl[d][int'(off) + i] = wd[8*(n-1-i) +: 8];
            return;
        end
        v = 0;
        for (int i = 0; i < n; i++) v = (v << 8) | longint'(mdl[d][int'(off) + i]);
        if (sgn && n < 4 && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
        rd = v[31:0];
    endfunction

    // Present a request and return just after its acceptance edge.
    task automatic issue(input bit wr, input logic [1:0] len, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wd);
        int n;
        @(negedge SYS_clk);
        req_write = wr; req_length = len; req_signed = sgn;
        req_address = addr; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        while (!w_req_ready && n < 2000) begin
            @(negedge SYS_clk);
            n++;
        end
        if (n >= 2000) chk("accept_timeout", 32'(n), 32'd0);
        @(posedge SYS_clk);
        #1 req_valid = 1'b0;
    endtask

    // Wait for the response, optionally stall it while offering a competing
    // store, then complete the handshake.
    task automatic finish_op(input string tag, input int hold, input logic [31:0] exp_rd,
                             input logic exp_flt, input int exp_lat,
                             output logic [31:0] obs_rd);
        int lat;
        lat = 0;
        while (!w_resp_valid && lat < 100) begin
            @(posedge SYS_clk);
            #1 lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, w_resp_rdata, exp_rd);
        chk({tag, "_fault"}, 32'(w_resp_fault), 32'(exp_flt));
        obs_rd = w_resp_rdata;
        if (hold > 0) begin
            req_write = 1'b1; req_length = LEN_WORD; req_signed = 1'b0;
            req_address = 32'h0000_1008; req_wdata = 32'h1111_1111; req_valid = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(posedge SYS_clk);
                #1;
                chk({tag, "_hold_valid"}, 32'(w_resp_valid), 32'd1);
                chk({tag, "_hold_rdata"}, w_resp_rdata, exp_rd);
                chk({tag, "_hold_fault"}, 32'(w_resp_fault), 32'(exp_flt));
                chk({tag, "_hold_req_ready"}, 32'(w_req_ready), 32'd0);
            end
            req_valid = 1'b0;
        end
        resp_ready = 1'b1;
        @(posedge SYS_clk);
        #1 resp_ready = 1'b0;
        chk({tag, "_post_valid"}, 32'(w_resp_valid), 32'd0);
        chk({tag, "_post_req_ready"}, 32'(w_req_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input bit wr, input logic [1:0] len, input bit sgn,
                          input logic [31:0] addr, input logic [31:0] wd, input int hold,
                          output logic [31:0] obs_rd);
        logic [31:0] exp_rd;
        logic        exp_flt;
        model_exec(int'(sel_b), wr, len, sgn, addr, wd, exp_rd, exp_flt);
        issue(wr, len, sgn, addr, wd);
        finish_op(tag, hold, exp_rd, exp_flt, sel_b ? 3 : 1, obs_rd);
    endtask

    task automatic count_clear(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge SYS_clk);
            #1 n++;
        end while (!bus_a.MEM_req_ready && n < 2000);
        chk(tag, 32'(n), 32'd256);
    endtask

    logic [31:0] obs;
    logic [31:0] exp_rd;
    logic        exp_flt;

    initial begin
        sel_b = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_signed = 1'b0;
        req_length = LEN_NOP; req_address = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        model_clear(0);
        model_clear(1);
        SYS_reset = 1'b1;
        repeat (3) @(posedge SYS_clk);
        #1;
        chk("rst_a_req_ready", 32'(bus_a.MEM_req_ready), 32'd0);
        chk("rst_a_resp_valid", 32'(bus_a.MEM_resp_valid), 32'd0);
        chk("rst_a_rdata", bus_a.MEM_resp_rdata, 32'h0);
        chk("rst_a_fault", 32'(bus_a.MEM_resp_fault), 32'd0);
        chk("rst_b_req_ready", 32'(bus_b.MEM_req_ready), 32'd0);
        chk("rst_b_resp_valid", 32'(bus_b.MEM_resp_valid), 32'd0);
        @(negedge SYS_clk) SYS_reset = 1'b0;
        count_clear("clear_cycles");

        run_op("t1_load", 1'b0, LEN_WORD, 1'b0, 32'h1000, 32'h0, 0, obs);
        chk("t1_lit", obs, 32'h0000_0000);

        run_op("t2_st", 1'b1, LEN_WORD, 1'b0, 32'h1004, 32'hDEAD_BEEF, 0, obs);
        chk("t2_st_lit", obs, 32'h0);
        run_op("t2_lbs", 1'b0, LEN_BYTE, 1'b1, 32'h1004, 32'h0, 0, obs);
        chk("t2_lbs_lit", obs, 32'hFFFF_FFDE);
        run_op("t2_lbu", 1'b0, LEN_BYTE, 1'b0, 32'h1007, 32'h0, 0, obs);
        chk("t2_lbu_lit", obs, 32'h0000_00EF);
        run_op("t2_lhs", 1'b0, LEN_HALF, 1'b1, 32'h1006, 32'h0, 0, obs);
        chk("t2_lhs_lit", obs, 32'hFFFF_BEEF);
        run_op("t2_lhu", 1'b0, LEN_HALF, 1'b0, 32'h1004, 32'h0, 0, obs);
        chk("t2_lhu_lit", obs, 32'h0000_DEAD);

        run_op("t3_sb", 1'b1, LEN_BYTE, 1'b0, 32'h1005, 32'h0000_005A, 0, obs);
        run_op("t3_lw", 1'b0, LEN_WORD, 1'b0, 32'h1004, 32'h0, 0, obs);
        chk("t3_lw_lit", obs, 32'hDE5A_BEEF);
        run_op("t3_top_sw", 1'b1, LEN_WORD, 1'b0, 32'h13FC, 32'h0102_0304, 0, obs);
        run_op("t3_top_lh", 1'b0, LEN_HALF, 1'b0, 32'h13FE, 32'h0, 0, obs);
        chk("t3_top_lit", obs, 32'h0000_0304);

        run_op("t4_mis_lw", 1'b0, LEN_WORD, 1'b0, 32'h1002, 32'h0, 0, obs);
        run_op("t4_mis_sh", 1'b1, LEN_HALF, 1'b0, 32'h1003, 32'h0000_FFFF, 0, obs);
        run_op("t4_lo", 1'b0, LEN_WORD, 1'b0, 32'h0FFC, 32'h0, 0, obs);
        run_op("t4_hi", 1'b0, LEN_WORD, 1'b0, 32'h1400, 32'h0, 0, obs);
        run_op("t4_wrap", 1'b1, LEN_BYTE, 1'b0, 32'h1001_1000, 32'h0000_0077, 0, obs);
        run_op("t4_nop", 1'b0, LEN_NOP, 1'b0, 32'h0FFC, 32'h0, 0, obs);
        run_op("t4_chk0", 1'b0, LEN_WORD, 1'b0, 32'h1000, 32'h0, 0, obs);
        chk("t4_chk0_lit", obs, 32'h0000_0000);
        run_op("t4_chk4", 1'b0, LEN_WORD, 1'b0, 32'h1004, 32'h0, 0, obs);
        chk("t4_chk4_lit", obs, 32'hDE5A_BEEF);

        run_op("t5_hold", 1'b0, LEN_WORD, 1'b0, 32'h1004, 32'h0, 5, obs);
        run_op("t5_nowrite", 1'b0, LEN_WORD, 1'b0, 32'h1008, 32'h0, 0, obs);
        chk("t5_nowrite_lit", obs, 32'h0000_0000);

        sel_b = 1'b1;
        run_op("b_sw", 1'b1, LEN_WORD, 1'b0, 32'h1010, 32'hA5A5_0F0F, 0, obs);
        run_op("b_lw", 1'b0, LEN_WORD, 1'b0, 32'h1010, 32'h0, 0, obs);
        chk("b_lw_lit", obs, 32'hA5A5_0F0F);
        run_op("b_lbs", 1'b0, LEN_BYTE, 1'b1, 32'h1011, 32'h0, 0, obs);
        run_op("b_mis", 1'b0, LEN_HALF, 1'b0, 32'h1011, 32'h0, 0, obs);
        run_op("b_sw2", 1'b1, LEN_WORD, 1'b0, 32'h1030, 32'h1234_5678, 0, obs);

        sel_b = 1'b0;
        for (int k = 0; k < 150; k++) begin
            bit          r_wr, r_sgn;
            logic [1:0]  r_len;
            logic [31:0] r_addr, r_wd;
            int          r_hold;
            r_wr  = 1'($urandom_range(0, 1));
            r_sgn = 1'($urandom_range(0, 1));
            r_len = 2'($urandom_range(0, 3));
            r_wd  = $urandom;
            if ($urandom_range(0, 7) == 0) r_addr = oor_addr[$urandom_range(0, 4)];
            else                           r_addr = 32'h1000 + 32'($urandom_range(0, 63));
            r_hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_op("rnd", r_wr, r_len, r_sgn, r_addr, r_wd, r_hold, obs);
        end

        run_op("t6a_sw", 1'b1, LEN_WORD, 1'b0, 32'h1020, 32'hCAFE_F00D, 0, obs);
        model_exec(0, 1'b0, LEN_WORD, 1'b0, 32'h1020, 32'h0, exp_rd, exp_flt);
        issue(1'b0, LEN_WORD, 1'b0, 32'h1020, 32'h0);
        #1 SYS_reset = 1'b1;
        #1;
        chk("t6a_rst_valid", 32'(bus_a.MEM_resp_valid), 32'd0);
        chk("t6a_rst_ready", 32'(bus_a.MEM_req_ready), 32'd0);
        model_clear(0);
        @(negedge SYS_clk) SYS_reset = 1'b0;
        count_clear("t6a_clear_cycles");
        run_op("t6a_lw", 1'b0, LEN_WORD, 1'b0, 32'h1020, 32'h0, 0, obs);
        chk("t6a_lw_lit", obs, 32'h0000_0000);
        sel_b = 1'b1;
        run_op("t6a_b_lw", 1'b0, LEN_WORD, 1'b0, 32'h1030, 32'h0, 0, obs);
        chk("t6a_b_lw_lit", obs, 32'h1234_5678);

        model_exec(1, 1'b1, LEN_WORD, 1'b0, 32'h1034, 32'h0BAD_CAFE, exp_rd, exp_flt);
        issue(1'b1, LEN_WORD, 1'b0, 32'h1034, 32'h0BAD_CAFE);
        #1 SYS_reset = 1'b1;
        #1;
        chk("t6b_rst_valid", 32'(bus_b.MEM_resp_valid), 32'd0);
        model_clear(0);
        @(negedge SYS_clk) SYS_reset = 1'b0;
        repeat (5) @(posedge SYS_clk);
        #1;
        chk("t6b_no_resp", 32'(bus_b.MEM_resp_valid), 32'd0);
        run_op("t6b_lw", 1'b0, LEN_WORD, 1'b0, 32'h1034, 32'h0, 0, obs);
        chk("t6b_lw_lit", obs, 32'h0BAD_CAFE);
        run_op("t6b_lw2", 1'b0, LEN_WORD, 1'b0, 32'h1030, 32'h0, 0, obs);
        sel_b = 1'b0;
        run_op("t6b_a_lw", 1'b0, LEN_WORD, 1'b0, 32'h1004, 32'h0, 0, obs);
        chk("t6b_a_lw_lit", obs, 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
